// File: rtl/fir_lane_packer.sv
// fir_lane_packer: packs PSAMPLES consecutive multi-channel sample beats into
// one wide parallel-lane word for the decimating FIR. Channel c, lane l sits
// at [(c*PSAMPLES+l)*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the oldest sample.
// The assembly register doubles as a skid stage, so the source can run at one
// beat per clock while the FIR is ready.
// Optional feature: define FIR_PACK_FLUSH_EN to add the flush input, which
// zero-fills and emits a partial frame.
module fir_lane_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int PSAMPLES   = 8
) (
  input  logic                                     clk,
  input  logic                                     nrst,
  input  logic                                     s_tvalid,
  output logic                                     s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]           s_tdata,
  output logic                                     m_tvalid,
  input  logic                                     m_tready,
  output logic [CHANNELS*DATA_WIDTH*PSAMPLES-1:0]  m_tdata,
  output logic [15:0]                              frame_cnt
`ifdef FIR_PACK_FLUSH_EN
  ,
  input  logic                                     flush
`endif
);

  localparam int LW = $clog2(PSAMPLES);
  localparam int WW = CHANNELS * DATA_WIDTH * PSAMPLES;
  localparam logic [LW-1:0] LAST_LANE = LW'(PSAMPLES - 1);

  logic [LW-1:0] lidx;
  logic [WW-1:0] asm_data;
  logic          asm_full;
  logic [WW-1:0] out_data;

  logic          accept;
  logic          out_free;
  logic          beat_last;
  logic          flush_fire;
  logic          frame_done;
  logic [LW-1:0] lidx_after;
  logic [WW-1:0] merged;
  logic [WW-1:0] frame_word;

  // The assembly register is the only buffer ahead of out, so it alone gates the source.
  assign s_tready   = !asm_full;
  assign accept     = s_tvalid && !asm_full;
  assign out_free   = !m_tvalid || m_tready;
  assign beat_last  = accept && (lidx == LAST_LANE);
  // Lane index after this cycle's beat; wraps to 0 when the beat completes a frame.
  assign lidx_after = accept ? lidx + LW'(1) : lidx;

`ifdef FIR_PACK_FLUSH_EN
  // A flush is applied after any same-cycle beat, and is moot if that beat already completed the frame.
  assign flush_fire = flush && !beat_last && (lidx_after != '0);
`else
  assign flush_fire = 1'b0;
`endif

  assign frame_done = beat_last || flush_fire;
  assign m_tdata    = out_data;

  // Merge the incoming beat into lane lidx of every channel.
  always_comb begin
    merged = asm_data;
    if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        merged[(c*PSAMPLES + int'(lidx))*DATA_WIDTH +: DATA_WIDTH] =
          s_tdata[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // On flush, lanes not yet written in this frame are forced to zero.
  always_comb begin
    frame_word = merged;
    if (flush_fire) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int l = 0; l < PSAMPLES; l++) begin
          if (l >= int'(lidx_after)) begin
            frame_word[(c*PSAMPLES + l)*DATA_WIDTH +: DATA_WIDTH] = '0;
          end
        end
      end
    end
  end

  // Lane assembly, skid hand-off and output register control.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lidx     <= '0;
      asm_data <= '0;
      asm_full <= 1'b0;
      out_data <= '0;
      m_tvalid <= 1'b0;
    end else begin
      if (frame_done) begin
        lidx <= '0;
      end else if (accept) begin
        lidx <= lidx + LW'(1);
      end

      if (asm_full && out_free) begin
        // Parked frame moves out; no beat can arrive this cycle since s_tready is low.
        out_data <= asm_data;
        m_tvalid <= 1'b1;
        asm_full <= 1'b0;
      end else if (frame_done && out_free) begin
        out_data <= frame_word;
        m_tvalid <= 1'b1;
      end else if (frame_done) begin
        asm_data <= frame_word;
        asm_full <= 1'b1;
      end else begin
        if (accept) begin
          asm_data <= merged;
        end
        if (m_tvalid && m_tready) begin
          m_tvalid <= 1'b0;
        end
      end
    end
  end

  // Count words accepted downstream; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frame_cnt <= '0;
    end else if (m_tvalid && m_tready) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fir_lane_packer.sv
// Testbench for fir_lane_packer: table-driven frames, full-rate ramp,
// backpressure, reset mid-stream and (with FIR_PACK_FLUSH_EN) flush.
module tb_fir_lane_packer;
  localparam int DW = 16;
  localparam int CH = 2;
  localparam int PS = 8;
  localparam int WW = DW * CH * PS;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [CH*DW-1:0] s_tdata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [WW-1:0] m_tdata;
  logic [15:0]   frame_cnt;
`ifdef FIR_PACK_FLUSH_EN
  logic          flush = 1'b0;
`endif

  fir_lane_packer #(.DATA_WIDTH(DW), .CHANNELS(CH), .PSAMPLES(PS)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .frame_cnt (frame_cnt)
`ifdef FIR_PACK_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string                 name;
    logic [PS-1:0][DW-1:0] in0;
    logic [PS-1:0][DW-1:0] in1;
    logic [WW-1:0]         expected;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [WW-1:0] sb_q[$];
  int            words_seen = 0;
  logic [WW-1:0] model_word = '0;
  int            model_lane = 0;
  bit            model_en = 1'b1;
  bit            prev_stall = 1'b0;
  logic [WW-1:0] prev_data = '0;
  bit            tready_low_seen = 1'b0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Monitor: sampled on the falling edge; a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (nrst) begin
      if (prev_stall) begin
        check("hold_valid", WW'(m_tvalid), WW'(1));
        check("hold_data", m_tdata, prev_data);
      end
      if (m_tvalid && m_tready) begin
        words_seen++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", m_tdata);
        end else begin
          check("word", m_tdata, sb_q.pop_front());
        end
      end
      if (!s_tready) tready_low_seen = 1'b1;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Offer one beat and return #1 after the edge that accepts it; s_tvalid is left high.
  task automatic send_beat(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = {c1, c0};
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accepted");
      s_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      model_word[model_lane*DW +: DW]        = c0;
      model_word[(PS + model_lane)*DW +: DW] = c1;
      model_lane++;
      if (model_lane == PS) begin
        if (model_en) sb_q.push_back(model_word);
        model_lane = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    nrst = 1'b0;
    #1;
    check("rst_m_tvalid", WW'(m_tvalid), WW'(0));
    check("rst_frame_cnt", WW'(frame_cnt), WW'(0));
    check("rst_s_tready", WW'(s_tready), WW'(1));
    check("rst_m_tdata", m_tdata, '0);
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    model_lane = 0;
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t          vecs[3];
  logic [15:0]   fc0;
  int            ws0;
  logic [WW-1:0] exp_w;

  initial begin
    // Table: inputs per lane plus the full expected packed word.
    vecs[0].name = "impulse";
    vecs[0].in0 = '0;
    vecs[0].in1 = '0;
    vecs[0].in0[0] = 16'h7FFF;
    vecs[0].in1[0] = 16'h7FFF;
    vecs[0].expected = 256'h0000_0000_0000_0000_0000_0000_0000_7FFF_0000_0000_0000_0000_0000_0000_0000_7FFF;
    vecs[1].name = "lane_tags";
    for (int l = 0; l < PS; l++) begin
      vecs[1].in0[l] = 16'h1100 + 16'(l);
      vecs[1].in1[l] = 16'h2200 + 16'(l);
    end
    vecs[1].expected = 256'h2207_2206_2205_2204_2203_2202_2201_2200_1107_1106_1105_1104_1103_1102_1101_1100;
    vecs[2].name = "extremes";
    for (int l = 0; l < PS; l++) begin
      vecs[2].in0[l] = (l % 2 == 1) ? 16'hFFFF : 16'h8000;
      vecs[2].in1[l] = 16'h5A5A;
    end
    vecs[2].expected = 256'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_FFFF_8000_FFFF_8000_FFFF_8000_FFFF_8000;

    // Power-on reset state.
    repeat (3) @(posedge clk);
    #1;
    check("init_m_tvalid", WW'(m_tvalid), WW'(0));
    check("init_m_tdata", m_tdata, '0);
    check("init_frame_cnt", WW'(frame_cnt), WW'(0));
    check("init_s_tready", WW'(s_tready), WW'(1));
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames, back to back; word must be valid right after its last beat.
    model_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(vecs[i].expected);
      for (int l = 0; l < PS; l++) send_beat(vecs[i].in0[l], vecs[i].in1[l]);
      check({vecs[i].name, "_valid_latency"}, WW'(m_tvalid), WW'(1));
    end
    model_en = 1'b1;
    idle(4);

    // Full-rate ramp: ch0 = n, ch1 = -n.
    fc0 = frame_cnt;
    tready_low_seen = 1'b0;
    for (int n = 0; n < 64; n++) begin
      send_beat(16'(n), 16'(-n));
      if (n % PS == PS - 1) check("ramp_valid", WW'(m_tvalid), WW'(1));
    end
    idle(3);
    check("ramp_tready_never_low", WW'(tready_low_seen), WW'(0));
    check("ramp_frame_cnt", WW'(frame_cnt), WW'(16'(fc0 + 16'd8)));

    // Backpressure: FIR stalled for 30 cycles while three frames are offered.
    fork
      begin
        m_tready = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        check("tready_release", WW'(s_tready), WW'(1));
      end
      begin
        for (int k = 0; k < 3*PS; k++) begin
          send_beat(16'h0100 + 16'(k), 16'h0200 + 16'(k));
          if (k == 2*PS - 1) begin
            check("tready_fall", WW'(s_tready), WW'(0));
            check("stall_valid", WW'(m_tvalid), WW'(1));
          end
        end
      end
    join
    idle(6);

    // Reset with a pending word and a partial frame, then one clean frame.
    m_tready = 1'b0;
    for (int k = 0; k < PS + 3; k++) send_beat(16'h0300 + 16'(k), 16'h0400 + 16'(k));
    do_reset();
    m_tready = 1'b1;
    ws0 = words_seen;
    for (int k = 0; k < PS; k++) send_beat(16'h0010 + 16'(k), 16'h0020 + 16'(k));
    idle(4);
    check("post_reset_one_word", WW'(words_seen), WW'(ws0 + 1));
    check("post_reset_frame_cnt", WW'(frame_cnt), WW'(1));

`ifdef FIR_PACK_FLUSH_EN
    // Flush a 3-beat partial frame, then flush at lane 0 which must do nothing.
    model_en = 1'b0;
    ws0 = words_seen;
    exp_w = '0;
    exp_w[0*DW +: DW] = 16'd1;
    exp_w[1*DW +: DW] = 16'd2;
    exp_w[2*DW +: DW] = 16'd3;
    exp_w[(PS+0)*DW +: DW] = 16'h000A;
    exp_w[(PS+1)*DW +: DW] = 16'h000B;
    exp_w[(PS+2)*DW +: DW] = 16'h000C;
    sb_q.push_back(exp_w);
    send_beat(16'd1, 16'h000A);
    send_beat(16'd2, 16'h000B);
    send_beat(16'd3, 16'h000C);
    s_tvalid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_lane = 0;
    check("flush_valid", WW'(m_tvalid), WW'(1));
    idle(3);
    check("flush_one_word", WW'(words_seen), WW'(ws0 + 1));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle(4);
    check("flush_idle_no_word", WW'(words_seen), WW'(ws0 + 1));
    model_en = 1'b1;
`endif

    // Drain and confirm every expected word arrived.
    for (int n = 0; n < 200 && sb_q.size() != 0; n++) @(negedge clk);
    check("queue_drained", WW'(sb_q.size()), WW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_lane_packer.md
# fir_lane_packer

Input-side packer for the dual-channel, decimate-by-8 FIR. Accepts one time-aligned sample pair per handshake (all channels in one beat) and assembles PSAMPLES consecutive pairs into the wide parallel-lane word the FIR consumes, with channel 1 in the upper half. A skid register decouples the source from FIR stalls, so throughput is one sample pair per clock at full rate.

## Interface
- DATA_WIDTH, 16: sample width, signed two's complement.
- CHANNELS, 2: channels per beat.
- PSAMPLES, 8: lanes per channel per output word; must be a power of two, ≥2.
- clk  in  1: single clock; all logic on rising edge.
- nrst  in  1: reset, asynchronous, active-low.
- s_tvalid  in  1: input beat valid.
- s_tready  out  1: packer can accept a beat.
- s_tdata  in  CHANNELS*DATA_WIDTH: channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- m_tvalid  out  1: packed word valid.
- m_tready  in  1: FIR accepts the word.
- m_tdata  out  CHANNELS*DATA_WIDTH*PSAMPLES: channel c lane l at [(c*PSAMPLES+l)*DATA_WIDTH +: DATA_WIDTH].
- frame_cnt  out  16: count of words accepted downstream; wraps 0xFFFF→0.
- flush  in  1: only present with FIR_PACK_FLUSH_EN.

## Operation
- Beat k of a frame (k = 0..PSAMPLES-1) lands in lane k of every channel; lane 0 is the oldest sample. Samples are copied bit-exact; no arithmetic.
- State: lane index lidx (log2 PSAMPLES bits), assembly register asm plus asm_full flag, output register out plus m_tvalid.
- s_tready = !asm_full (combinational).
- Beat accepted (s_tvalid && s_tready) with lidx < PSAMPLES-1: write lane lidx of asm; lidx++.
- Beat accepted with lidx = PSAMPLES-1: lidx wraps to 0. If out is free (!m_tvalid || m_tready), the completed frame (asm with the final lane merged) loads directly into out and m_tvalid is set. Otherwise asm_full is set.
- asm_full && out free: asm moves to out, m_tvalid = 1, asm_full cleared in the same cycle.
- m_tvalid && m_tready with nothing to load: m_tvalid cleared. m_tdata holds its last value.
- frame_cnt increments on every m_tvalid && m_tready.
- m_tdata and m_tvalid stay stable while m_tvalid && !m_tready (AXI-stream rule).
- Simultaneous events:
  - Downstream accept and a new frame completing in the same cycle: the new frame loads out, and m_tvalid stays 1.
  - Downstream accept while asm_full: asm is loaded. No cycle gap.
- No beat is ever dropped or duplicated.

## Timing
- Reset values:
  - m_tvalid 0, m_tdata 0, frame_cnt 0, s_tready 1.
  - lidx 0, asm_full 0, asm 0.
  - Source must hold s_tvalid low during reset.
- Latency: m_tvalid rises on the edge that accepts the final beat, so it is visible the next cycle, provided out is free.
- Sustained rate: with m_tready high, one frame per PSAMPLES cycles and s_tready never deasserts.
- Stall: with m_tready held low, the source can place at most 2*PSAMPLES beats. s_tready falls the cycle after the beat that completes the second frame. It rises the cycle after m_tready is sampled high.
- Reset mid-frame: the partial frame and any pending word are discarded, and lidx returns to 0. The first beat after release is lane 0.

## Configuration
- FIR_PACK_FLUSH_EN defined:
  - flush port exists. A one-cycle flush with lidx > 0 zero-fills lanes lidx..PSAMPLES-1 and completes the frame through the normal path (direct to out or via asm_full). lidx then returns to 0.
  - flush with lidx = 0 is ignored.
  - flush in the same cycle as an accepted beat: the beat is merged first, then flush is applied. If that beat completes the frame, flush is ignored.
- FIR_PACK_FLUSH_EN undefined: no flush port. A partial frame is held indefinitely until its remaining beats arrive.

## Test plan
- Reset: assert nrst low mid-stream → m_tvalid 0, frame_cnt 0, s_tready 1. After release, the next 8 beats form one clean frame.
- Impulse: beat 0 = {0x7FFF, 0x7FFF}, beats 1–7 zero, m_tready 1 → one word with bits[15:0] = 0x7FFF and bits[143:128] = 0x7FFF, all else 0. m_tvalid appears the cycle after beat 7.
- Ramp at full rate: ch0 = n, ch1 = -n for n = 0..63, m_tready 1 → 8 words, one every 8 cycles. Word f: ch0 lane l = 8f+l, ch1 lane l = -(8f+l). s_tready is never low, and frame_cnt = 8.
- Backpressure: m_tready 0 for 30 cycles while feeding continuously → word 0 stable throughout. s_tready falls after beat 15 is accepted. After release, words 0, 1, 2 arrive in order with no loss.
- Mid-frame reset: feed 3 beats, pulse nrst low, then feed 8 beats 0x10..0x17 → exactly one word, with lanes 0x10..0x17.
- Flush (FIR_PACK_FLUSH_EN): beats 1, 2, 3 then flush → ch0 lanes 0–2 = 1, 2, 3 and lanes 3–7 = 0. A second flush at lidx 0 produces no word.
